// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_pkg
// Purpose  : Shared types and helpers for the multi-channel SAR ADC scanner:
//            scan state encoding and enabled-channel search.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
package sar_adc_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_HOLD    = 2'd3
  } sar_state_e;

  // Widest channel mask the search helper understands; callers zero-extend.
  localparam int C_MAX_CHANNELS = 64;

  // Index of the lowest set bit of mask at or above 'from', or -1 when none.
  // next_enabled_ch(mask, 0) gives the lowest enabled channel.
  function automatic int next_enabled_ch(input logic [C_MAX_CHANNELS-1:0] mask,
                                         input int from);
    int idx;
    idx = -1;
    for (int i = C_MAX_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_bit_engine.sv
`default_nettype none
// ============================================================================
// Module   : sar_bit_engine
// Purpose  : Binary-search core of a SAR conversion. Holds the trial-bit mask
//            and partial result, presents the DAC trial code, and flags the
//            LSB decision so the caller can capture the finished result.
// Revision : 1.0 - initial release
// ============================================================================
module sar_bit_engine
  import sar_adc_pkg::*;
#(
  parameter int RESOLUTION = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,    // arm for a new conversion
  input  logic                  step_i,    // one bit decision this cycle
  input  logic                  comp_i,    // 1: Vin >= trial code
  output logic [RESOLUTION-1:0] trial_o,   // code to drive onto the DAC
  output logic [RESOLUTION-1:0] result_o,  // result including this cycle's decision
  output logic                  done_o     // this step decides the LSB
);

  localparam logic [RESOLUTION-1:0] c_msb = {1'b1, {(RESOLUTION-1){1'b0}}};

  logic [RESOLUTION-1:0] r_mask;
  logic [RESOLUTION-1:0] r_result;
  logic [RESOLUTION-1:0] w_result_upd;

  assign trial_o      = r_result | r_mask;
  assign w_result_upd = comp_i ? trial_o : r_result;
  assign result_o     = w_result_upd;
  assign done_o       = step_i & r_mask[0];

  // Keep the trial bit on success, then move the mask one bit toward the LSB
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mask   <= '0;
      r_result <= '0;
    end else if (load_i) begin
      r_mask   <= c_msb;
      r_result <= '0;
    end else if (step_i) begin
      r_result <= w_result_upd;
      r_mask   <= r_mask >> 1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_adc_scan.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_scan
// Purpose  : Multi-channel SAR ADC scan controller. Steps an analog mux over
//            the enabled channels, runs settle/sample then a binary-search
//            conversion per channel, and offers each result on a valid/ready
//            port tagged with its channel. One-shot and continuous scans.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module sar_adc_scan
  import sar_adc_pkg::*;
#(
  parameter int  RESOLUTION    = 8,
  parameter int  CHANNELS      = 4,
  parameter int  SETTLE_CYCLES = 2,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  cont_i,
  input  logic                  stop_i,
  input  logic [CHANNELS-1:0]   ch_en_i,
  input  logic                  comp_i,
  output logic [CH_W-1:0]       ch_sel_o,
  output logic                  sample_o,
  output logic [RESOLUTION-1:0] dac_o,
  output logic                  busy_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [RESOLUTION-1:0] data_o,
  output logic [CH_W-1:0]       ch_o
);

  localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);

  sar_state_e              r_state;
  sar_state_e              w_state_next;
  logic [CHANNELS-1:0]     r_ch_en;
  logic                    r_cont;
  logic                    r_stop;
  logic [CH_W-1:0]         r_ch_sel;
  logic [CH_W-1:0]         r_ch;
  logic [RESOLUTION-1:0]   r_data;
  logic [c_settle_w-1:0]   r_settle;

  logic                    w_start;
  logic                    w_load;
  logic                    w_step;
  logic                    w_capture;
  logic                    w_advance;
  logic                    w_wrap;
  logic                    w_stop_pend;
  logic                    w_next_found;
  logic                    w_done;
  logic [RESOLUTION-1:0]   w_trial;
  logic [RESOLUTION-1:0]   w_final;
  int                      w_first_idx;
  int                      w_lowest_idx;
  int                      w_next_idx;

  // Channel search: first channel of a new scan, wrap target, next channel up
  assign w_first_idx  = next_enabled_ch(C_MAX_CHANNELS'(ch_en_i), 0);
  assign w_lowest_idx = next_enabled_ch(C_MAX_CHANNELS'(r_ch_en), 0);
  assign w_next_idx   = next_enabled_ch(C_MAX_CHANNELS'(r_ch_en), int'(r_ch_sel) + 1);
  assign w_next_found = (w_next_idx >= 0);

  // A stop raised in the very cycle the result is accepted still counts
  assign w_stop_pend = r_stop | stop_i;

  sar_bit_engine #(
    .RESOLUTION (RESOLUTION)
  ) u_bit_engine (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (w_load),
    .step_i   (w_step),
    .comp_i   (comp_i),
    .trial_o  (w_trial),
    .result_o (w_final),
    .done_o   (w_done)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_wrap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && (|ch_en_i)) begin
          w_state_next = ST_SAMPLE;
          w_start      = 1'b1;
        end
      end
      ST_SAMPLE: begin
        w_load = 1'b1;
        if (r_settle == c_settle_last) w_state_next = ST_CONVERT;
      end
      ST_CONVERT: begin
        w_step = 1'b1;
        if (w_done) begin
          w_state_next = ST_HOLD;
          w_capture    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ready_i) begin
          if (w_stop_pend) begin
            w_state_next = ST_IDLE;
          end else if (w_next_found) begin
            w_state_next = ST_SAMPLE;
            w_advance    = 1'b1;
          end else if (r_cont) begin
            w_state_next = ST_SAMPLE;
            w_wrap       = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Settle counter: counts sample cycles, restarts for every channel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                            r_settle <= '0;
    else if ((r_state == ST_SAMPLE) && (r_settle != c_settle_last)) r_settle <= r_settle + 1'b1;
    else                                                    r_settle <= '0;
  end

  // Scan configuration and mux select; select moves only when entering SAMPLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ch_en  <= '0;
      r_cont   <= 1'b0;
      r_ch_sel <= '0;
    end else if (w_start) begin
      r_ch_en  <= ch_en_i;
      r_cont   <= cont_i;
      r_ch_sel <= CH_W'(w_first_idx);
    end else if (w_advance) begin
      r_ch_sel <= CH_W'(w_next_idx);
    end else if (w_wrap) begin
      r_ch_sel <= CH_W'(w_lowest_idx);
    end
  end

  // Sticky stop request, dropped once the scan is idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  r_stop <= 1'b0;
    else if (r_state == ST_IDLE)  r_stop <= 1'b0;
    else if (stop_i)              r_stop <= 1'b1;
  end

  // Result register, loaded on the LSB decision and held through HOLD
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_ch   <= '0;
    end else if (w_capture) begin
      r_data <= w_final;
      r_ch   <= r_ch_sel;
    end
  end

  assign ch_sel_o = r_ch_sel;
  assign sample_o = (r_state == ST_SAMPLE);
  assign dac_o    = (r_state == ST_CONVERT) ? w_trial : '0;
  assign busy_o   = (r_state != ST_IDLE);
  assign valid_o  = (r_state == ST_HOLD);
  assign data_o   = r_data;
  assign ch_o     = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_scan
// Purpose  : Self-checking bench for sar_adc_scan with an ideal comparator
//            and a reference model of scan order and SAR trial codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_scan;

  localparam int R   = 8;
  localparam int NCH = 4;
  localparam int S   = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           start_i;
  logic           cont_i;
  logic           stop_i;
  logic [NCH-1:0] ch_en_i;
  logic           comp_i;
  logic [1:0]     ch_sel_o;
  logic           sample_o;
  logic [R-1:0]   dac_o;
  logic           busy_o;
  logic           valid_o;
  logic           ready_i;
  logic [R-1:0]   data_o;
  logic [1:0]     ch_o;

  logic [R-1:0]   vin [NCH];
  int             n_checks = 0;
  int             n_errors = 0;

  sar_adc_scan #(
    .RESOLUTION    (R),
    .CHANNELS      (NCH),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .cont_i   (cont_i),
    .stop_i   (stop_i),
    .ch_en_i  (ch_en_i),
    .comp_i   (comp_i),
    .ch_sel_o (ch_sel_o),
    .sample_o (sample_o),
    .dac_o    (dac_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .ch_o     (ch_o)
  );

  always #5 clk_i = ~clk_i;

  // Ideal comparator on the selected input
  assign comp_i = (vin[ch_sel_o] >= dac_o);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Trial k of a binary search for v: bits of v above the trial bit, plus the trial bit
  function automatic logic [R-1:0] trial_code(input logic [R-1:0] v, input int k);
    int keep;
    int code;
    keep = R - k;
    code = ((int'(v) >> keep) << keep) | (1 << (R - 1 - k));
    return code[R-1:0];
  endfunction

  // One channel from its first SAMPLE cycle through acceptance of its result.
  // Busy-time junk on start/mask/mode must be ignored by the DUT.
  task automatic run_channel(input int ch, input int hold, input int stop_k);
    for (int k = 0; k <= S + R; k++) begin
      @(negedge clk_i);
      start_i = (k < S + R) ? 1'($urandom) : 1'b0;
      ch_en_i = 4'($urandom);
      cont_i  = 1'($urandom);
      stop_i  = (k == stop_k);
      if ((k == 0) && (hold > 0)) ready_i = 1'b0;
      check("ch_sel", 32'(ch_sel_o), 32'(ch));
      check("busy", 32'(busy_o), 32'd1);
      check("sample", 32'(sample_o), 32'(k < S));
      check("dac", 32'(dac_o), (k >= S && k < S + R) ? 32'(trial_code(vin[ch], k - S)) : 32'd0);
      check("valid", 32'(valid_o), 32'(k == S + R));
    end
    check("data", 32'(data_o), 32'(vin[ch]));
    check("ch_o", 32'(ch_o), 32'(ch));
    stop_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_data", 32'(data_o), 32'(vin[ch]));
      check("hold_ch", 32'(ch_o), 32'(ch));
      check("hold_sample", 32'(sample_o), 32'd0);
      check("hold_dac", 32'(dac_o), 32'd0);
    end
    ready_i = 1'b1;
  endtask

  // Full scan: expected channel order built from the mask; optional truncation
  // to max_res results with a stop pulse during the last one's conversion.
  task automatic run_scan(input logic [NCH-1:0] mask, input logic cont, input int passes,
                          input int max_res, input int hold_first, input int stop_last_k);
    int order[$];
    int seq[$];
    for (int c = 0; c < NCH; c++) if (mask[c]) order.push_back(c);
    for (int p = 0; p < passes; p++) foreach (order[i]) seq.push_back(order[i]);
    while ((max_res > 0) && (seq.size() > max_res)) void'(seq.pop_back());
    @(negedge clk_i);
    start_i = 1'b1;
    ch_en_i = mask;
    cont_i  = cont;
    ready_i = 1'b1;
    foreach (seq[i])
      run_channel(seq[i], (i == 0) ? hold_first : 0, (i == seq.size() - 1) ? stop_last_k : -1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      check("end_busy", 32'(busy_o), 32'd0);
      check("end_valid", 32'(valid_o), 32'd0);
      check("end_sample", 32'(sample_o), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ch_sel"}, 32'(ch_sel_o), 32'd0);
    check({tag, "_sample"}, 32'(sample_o), 32'd0);
    check({tag, "_dac"}, 32'(dac_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_data"}, 32'(data_o), 32'd0);
    check({tag, "_ch_o"}, 32'(ch_o), 32'd0);
  endtask

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    cont_i  = 1'b0;
    stop_i  = 1'b0;
    ch_en_i = '0;
    ready_i = 1'b1;
    for (int c = 0; c < NCH; c++) vin[c] = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // One-shot single channel, worked example
    vin[0] = 8'hA5;
    run_scan(4'b0001, 1'b0, 1, 0, 0, -1);

    // One-shot, sparse mask with extreme inputs
    vin[1] = 8'h00;
    vin[3] = 8'hFF;
    run_scan(4'b1010, 1'b0, 1, 0, 0, -1);

    // Continuous with 20 cycles of backpressure on the first result
    for (int c = 0; c < NCH; c++) vin[c] = 8'($urandom);
    run_scan(4'b0111, 1'b1, 2, 4, 20, S + 5);

    // Continuous, stop mid-conversion of ch1: ch1 delivered, no ch2
    for (int c = 0; c < NCH; c++) vin[c] = 8'($urandom);
    run_scan(4'b0111, 1'b1, 1, 2, 0, S + 3);

    // Start with empty mask is ignored
    @(negedge clk_i);
    start_i = 1'b1;
    ch_en_i = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      check("nomask_busy", 32'(busy_o), 32'd0);
      check("nomask_sample", 32'(sample_o), 32'd0);
    end
    start_i = 1'b0;

    // Reset during the 4th conversion cycle, then a clean conversion
    vin[0] = 8'($urandom);
    @(negedge clk_i);
    start_i = 1'b1;
    ch_en_i = 4'b0001;
    cont_i  = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (S + 3) @(negedge clk_i);
    check("prerst_dac", 32'(dac_o), 32'(trial_code(vin[0], 3)));
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_scan(4'b0001, 1'b0, 1, 0, 0, -1);

    // Randomized scans against the model
    for (int it = 0; it < 10; it++) begin
      logic [NCH-1:0] m;
      logic           cn;
      m  = 4'($urandom_range(1, 15));
      cn = 1'($urandom);
      for (int c = 0; c < NCH; c++) vin[c] = 8'($urandom);
      run_scan(m, cn, cn ? 2 : 1, 0, $urandom_range(0, 3),
               cn ? S + $urandom_range(0, R - 1) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
